// File: rtl/gl_decode.sv
// gl_decode: decode stage between gl_fetch and the transform stage.
//
// Takes one command word (opcode in [7:0]) plus the operand base address from
// fetch, burst-reads the opcode's operand words from the command BRAM, packs
// them into one wide bundle and offers it downstream with valid/ready.
//
// Ports:
//   clk, reset   clock (rising edge) and asynchronous active-high reset
//   in_inst      command word from fetch
//   in_base      address of first operand word
//   in_valid     command qualifier, sampled only while stall is low
//   stall        back-pressure to fetch (busy reading or bundle not yet taken)
//   bram_addr    registered operand read address
//   bram_en      registered read enable
//   bram_rdata   read data, one cycle after the address is presented
//   out_inst     command word of the current bundle
//   out_count    number of valid operand words in out_data
//   out_data     operand words, word i at [WIDTH*i +: WIDTH], unused slots zero
//   out_valid    bundle valid, held until out_ready
//   out_ready    downstream accept
module gl_decode #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_WORDS  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              in_inst,
  input  logic [ADDR_WIDTH-1:0]         in_base,
  input  logic                          in_valid,
  output logic                          stall,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic                          bram_en,
  input  logic [WIDTH-1:0]              bram_rdata,
  output logic [WIDTH-1:0]              out_inst,
  output logic [$clog2(MAX_WORDS):0]    out_count,
  output logic [WIDTH*MAX_WORDS-1:0]    out_data,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int unsigned CntW = $clog2(MAX_WORDS) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StEmit
  } state_e;

  state_e                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       bram_addr_q, bram_addr_d;
  logic                        bram_en_q, bram_en_d;
  // High in the cycle where bram_rdata holds a requested operand word.
  logic                        rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0]            out_inst_q, out_inst_d;
  logic [CntW-1:0]             out_count_q, out_count_d;
  logic [WIDTH*MAX_WORDS-1:0]  out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;
  // Addresses issued so far, and next slot to capture.
  logic [CntW-1:0]             issue_q, issue_d;
  logic [CntW-1:0]             cap_q, cap_d;

  logic [7:0]                  opcode;
  logic [CntW-1:0]             in_words;
  logic                        dropped;
  logic                        accept;

  function automatic logic [CntW-1:0] opcode_words(input logic [7:0] op);
    case (op)
      8'h03, 8'h04: return CntW'(3);
      8'h11, 8'h13: return CntW'(16);
      8'h19:        return CntW'(4);
      default:      return '0;
    endcase
  endfunction

  assign opcode   = in_inst[7:0];
  assign in_words = opcode_words(opcode);
  assign dropped  = (opcode == 8'h00) || (opcode == 8'h06);

  // Stall drops in the cycle the bundle is taken, so fetch can hand over the
  // next command on the transfer edge.
  assign stall  = (state_q == StRead) || ((state_q == StEmit) && !out_ready);
  assign accept = in_valid && !stall;

  always_comb begin
    state_d     = state_q;
    bram_addr_d = bram_addr_q;
    bram_en_d   = bram_en_q;
    rd_valid_d  = bram_en_q;
    out_inst_d  = out_inst_q;
    out_count_d = out_count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    issue_d     = issue_q;
    cap_d       = cap_q;

    case (state_q)
      StRead: begin
        if (bram_en_q) begin
          if (issue_q < out_count_q) begin
            bram_addr_d = bram_addr_q + ADDR_WIDTH'(1);
            issue_d     = issue_q + CntW'(1);
          end else begin
            bram_en_d = 1'b0;
          end
        end
        if (rd_valid_q) begin
          out_data_d[WIDTH*cap_q +: WIDTH] = bram_rdata;
          cap_d = cap_q + CntW'(1);
          // Last word lands on the same edge that raises out_valid.
          if (cap_q == out_count_q - CntW'(1)) begin
            state_d     = StEmit;
            out_valid_d = 1'b1;
          end
        end
      end
      StEmit: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // A new command may arrive on the transfer edge and overrides the above.
    if (accept && !dropped) begin
      out_inst_d  = in_inst;
      out_count_d = in_words;
      out_data_d  = '0;
      cap_d       = '0;
      if (in_words != '0) begin
        state_d     = StRead;
        bram_addr_d = in_base;
        bram_en_d   = 1'b1;
        issue_d     = CntW'(1);
        out_valid_d = 1'b0;
      end else begin
        state_d     = StEmit;
        issue_d     = '0;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      bram_addr_q <= '0;
      bram_en_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      out_inst_q  <= '0;
      out_count_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      issue_q     <= '0;
      cap_q       <= '0;
    end else begin
      state_q     <= state_d;
      bram_addr_q <= bram_addr_d;
      bram_en_q   <= bram_en_d;
      rd_valid_q  <= rd_valid_d;
      out_inst_q  <= out_inst_d;
      out_count_q <= out_count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      issue_q     <= issue_d;
      cap_q       <= cap_d;
    end
  end

  assign bram_addr = bram_addr_q;
  assign bram_en   = bram_en_q;
  assign out_inst  = out_inst_q;
  assign out_count = out_count_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_gl_decode.sv
// Self-checking bench for gl_decode: directed scenarios plus a randomized
// command stream, checked against a bundle model built from the opcode table
// and a behavioural BRAM.
module tb_gl_decode;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  in_inst;
  logic [31:0]  in_base;
  logic         in_valid;
  logic         stall;
  logic [31:0]  bram_addr;
  logic         bram_en;
  logic [31:0]  bram_rdata;
  logic [31:0]  out_inst;
  logic [4:0]   out_count;
  logic [511:0] out_data;
  logic         out_valid;
  logic         out_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int xfers    = 0;

  logic [31:0]  mem [logic [31:0]];

  // Expected bundle of the command currently in flight.
  logic [31:0]  exp_inst;
  int           exp_n;
  logic [511:0] exp_data;

  gl_decode dut (
    .clk        (clk),
    .reset      (reset),
    .in_inst    (in_inst),
    .in_base    (in_base),
    .in_valid   (in_valid),
    .stall      (stall),
    .bram_addr  (bram_addr),
    .bram_en    (bram_en),
    .bram_rdata (bram_rdata),
    .out_inst   (out_inst),
    .out_count  (out_count),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous-read BRAM: data for the address of cycle c shows in cycle c+1.
  always @(posedge clk) begin
    if (bram_en) bram_rdata <= mem_rd(bram_addr);
  end

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) xfers <= xfers + 1;
  end

  function automatic int model_n(input logic [7:0] op);
    if (op == 8'h03 || op == 8'h04) return 3;
    if (op == 8'h11 || op == 8'h13) return 16;
    if (op == 8'h19) return 4;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for stall low, presents the command for one edge (E0).
  task automatic accept_cmd(input logic [31:0] inst, input logic [31:0] base);
    int w = 0;
    while (stall && w < 40) begin
      step();
      w++;
    end
    n_checks++;
    if (stall) $display("FAIL accept_wait: stall=%0b required 0", stall);
    else n_pass++;
    in_inst  = inst;
    in_base  = base;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Called just after E0: checks the read burst, latency and bundle contents,
  // returns with out_valid observed high.
  task automatic expect_bundle(input logic [31:0] inst, input logic [31:0] base);
    int  c = 0;
    bit  seen = 0;
    exp_inst = inst;
    exp_n    = model_n(inst[7:0]);
    exp_data = '0;
    for (int i = 0; i < exp_n; i++) exp_data[32*i +: 32] = mem_rd(base + i);
    while (!seen && c <= exp_n + 4) begin
      if (exp_n > 0 && c < exp_n) begin
        n_checks++;
        if (bram_addr !== base + c || bram_en !== 1'b1)
          $display("FAIL read_addr c=%0d: addr=%h en=%b required addr=%h en=1",
                   c, bram_addr, bram_en, base + c);
        else n_pass++;
      end
      if (exp_n > 0 && c == exp_n) begin
        n_checks++;
        if (bram_en !== 1'b0) $display("FAIL read_end: en=%b required 0", bram_en);
        else n_pass++;
      end
      if (exp_n > 0 && c <= exp_n) begin
        n_checks++;
        if (stall !== 1'b1) $display("FAIL busy_stall c=%0d: stall=%b required 1", c, stall);
        else n_pass++;
      end
      if (out_valid === 1'b1) seen = 1;
      else begin
        step();
        c++;
      end
    end
    n_checks++;
    if (!seen) $display("FAIL latency: out_valid never rose, required at E0+%0d",
                        exp_n == 0 ? 0 : exp_n + 1);
    else if (c != (exp_n == 0 ? 0 : exp_n + 1))
      $display("FAIL latency: out_valid at E0+%0d required E0+%0d", c, exp_n + 1);
    else n_pass++;
    n_checks++;
    if (out_inst !== exp_inst || out_count !== 5'(exp_n) || out_data !== exp_data)
      $display("FAIL bundle: inst=%h count=%0d data=%h required inst=%h count=%0d data=%h",
               out_inst, out_count, out_data, exp_inst, exp_n, exp_data);
    else n_pass++;
  endtask

  // Holds ready low for 'hold' cycles (optionally pulsing in_valid), then transfers.
  task automatic deliver(input int hold, input bit poke);
    int x0;
    out_ready = 1'b0;
    for (int d = 0; d < hold; d++) begin
      if (poke) begin
        in_inst  = 32'h0000_0003;
        in_base  = 32'h0000_0040;
        in_valid = 1'b1;
      end
      n_checks++;
      if (out_valid !== 1'b1 || stall !== 1'b1 || out_inst !== exp_inst ||
          out_count !== 5'(exp_n) || out_data !== exp_data)
        $display("FAIL hold d=%0d: valid=%b stall=%b inst=%h count=%0d required held bundle",
                 d, out_valid, stall, out_inst, out_count);
      else n_pass++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) $display("FAIL ready_stall: stall=%b required 0", stall);
    else n_pass++;
    x0 = xfers;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || xfers != x0 + 1 || stall !== 1'b0)
      $display("FAIL transfer: valid=%b xfers=%0d stall=%b required valid=0 xfers=%0d stall=0",
               out_valid, xfers, stall, x0 + 1);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_base   = '0;
    out_ready = 1'b0;
    #12;
    n_checks++;
    if (out_valid !== 1'b0 || bram_en !== 1'b0 || bram_addr !== '0 || out_inst !== '0 ||
        out_count !== '0 || out_data !== '0 || stall !== 1'b0)
      $display("FAIL reset_state: valid=%b en=%b addr=%h inst=%h count=%0d stall=%b required zeros",
               out_valid, bram_en, bram_addr, out_inst, out_count, stall);
    else n_pass++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_vertex();
    mem[32'd1] = 32'h3F80_0000;
    mem[32'd2] = 32'h4000_0000;
    mem[32'd3] = 32'h4040_0000;
    accept_cmd(32'h0000_0003, 32'd1);
    expect_bundle(32'h0000_0003, 32'd1);
    deliver(0, 0);
  endtask

  task automatic test_multmatrix();
    for (int i = 0; i < 16; i++) mem[32'h20 + i] = 32'h100 + i;
    accept_cmd(32'h8000_1011, 32'h20);
    expect_bundle(32'h8000_1011, 32'h20);
    deliver(0, 0);
  endtask

  task automatic test_backpressure();
    int x0;
    accept_cmd(32'h0000_0003, 32'd1);
    expect_bundle(32'h0000_0003, 32'd1);
    x0 = xfers;
    deliver(5, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0 || stall !== 1'b0 || xfers != x0 + 1)
        $display("FAIL bp_ignored k=%0d: valid=%b stall=%b xfers=%0d required 0 0 %0d",
                 k, out_valid, stall, xfers, x0 + 1);
      else n_pass++;
    end
  endtask

  task automatic test_dropped();
    accept_cmd(32'h0000_0006, 32'h55);
    accept_cmd(32'h0000_0000, 32'h66);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_valid !== 1'b0 || stall !== 1'b0 || bram_en !== 1'b0)
        $display("FAIL dropped k=%0d: valid=%b stall=%b en=%b required 0 0 0",
                 k, out_valid, stall, bram_en);
      else n_pass++;
      step();
    end
    accept_cmd(32'h0000_0007, 32'h77);
    expect_bundle(32'h0000_0007, 32'h77);
    deliver(1, 0);
  endtask

  task automatic test_reset_mid_read();
    accept_cmd(32'h0000_0011, 32'h20);
    for (int k = 0; k < 7; k++) step();
    n_checks++;
    if (bram_addr !== 32'h27) $display("FAIL mid_read_pos: addr=%h required 00000027", bram_addr);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || bram_en !== 1'b0 || bram_addr !== '0 || out_inst !== '0 ||
        out_count !== '0 || out_data !== '0 || stall !== 1'b0)
      $display("FAIL mid_reset: valid=%b en=%b addr=%h inst=%h count=%0d stall=%b required zeros",
               out_valid, bram_en, bram_addr, out_inst, out_count, stall);
    else n_pass++;
    #10;
    reset = 1'b0;
    step();
    test_vertex();
  endtask

  task automatic test_back_to_back();
    int x0;
    accept_cmd(32'h0000_0004, 32'd5);
    expect_bundle(32'h0000_0004, 32'd5);
    x0 = xfers;
    in_inst   = 32'h0000_0019;
    in_base   = 32'd9;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) $display("FAIL b2b_stall: stall=%b required 0", stall);
    else n_pass++;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (xfers != x0 + 1) $display("FAIL b2b_first: xfers=%0d required %0d", xfers, x0 + 1);
    else n_pass++;
    expect_bundle(32'h0000_0019, 32'd9);
    deliver(0, 0);
    n_checks++;
    if (xfers != x0 + 2) $display("FAIL b2b_total: xfers=%0d required %0d", xfers, x0 + 2);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0]  ops [9];
    logic [31:0] inst, base;
    int x0;
    ops = '{8'h03, 8'h04, 8'h11, 8'h13, 8'h19, 8'h00, 8'h06, 8'h07, 8'h2A};
    for (int t = 0; t < 24; t++) begin
      inst = {$urandom_range(0, 32'hFFFFFF), ops[$urandom_range(0, 8)]};
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      x0 = xfers;
      accept_cmd(inst, base);
      if (inst[7:0] == 8'h00 || inst[7:0] == 8'h06) begin
        n_checks++;
        if (out_valid !== 1'b0 || stall !== 1'b0 || xfers != x0)
          $display("FAIL rand_drop t=%0d: valid=%b stall=%b required 0 0", t, out_valid, stall);
        else n_pass++;
      end else begin
        expect_bundle(inst, base);
        deliver($urandom_range(0, 3), 0);
      end
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    test_reset();
    test_vertex();
    test_multmatrix();
    test_backpressure();
    test_dropped();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
